// File: rtl/sparse_dot_engine_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sparse_dot_pkg
//  Purpose  : Shared state encoding, width helpers and the saturating
//             narrowing function for the sparse dot-product engine.
//  Revision : 1.0 - initial release
// ============================================================================
package sparse_dot_pkg;

   // Engine sequencing states
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COMPUTE = 2'd1,
      ST_FINISH  = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   // Widest accumulator the narrowing function can accept
   localparam int SAT_MAX_W = 128;
   // Width of the cycle counter and its reported copy
   localparam int CNT_W     = 32;

   localparam logic [SAT_MAX_W-1:0] SAT_ONE = SAT_MAX_W'(1);

   typedef struct packed {
      logic [SAT_MAX_W-1:0] value;
      logic                 clipped;
   } sat_res_t;

   // Index register width: idx can run up to MAX_N-1+LANES before the exit test
   function automatic int idx_width(input int max_n, input int lanes);
      return $clog2(max_n + lanes + 1);
   endfunction

   // Clip a sign-extended value into signed out_w range when sat_en is set;
   // otherwise pass it through so the caller keeps only the low bits.
   function automatic sat_res_t sat_narrow(input logic signed [SAT_MAX_W-1:0] value,
                                           input int unsigned                 out_w,
                                           input logic                        sat_en);
      sat_res_t                    res;
      logic signed [SAT_MAX_W-1:0] hi;
      logic signed [SAT_MAX_W-1:0] lo;
      hi = $signed((SAT_ONE << (out_w - 1)) - SAT_ONE);
      lo = ~hi;
      res.value   = value;
      res.clipped = 1'b0;
      if (sat_en) begin
         if (value > hi) begin
            res.value   = hi;
            res.clipped = 1'b1;
         end else if (value < lo) begin
            res.value   = lo;
            res.clipped = 1'b1;
         end
      end
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sparse_dot_engine_lane_sum.sv
`default_nettype none
// ============================================================================
//  Module   : dot_lane_sum
//  Purpose  : Combinational LANES-wide masked multiply and sum. Lane k uses
//             operand pair idx+k; lanes at or beyond n contribute zero.
//  Revision : 1.0 - initial release
// ============================================================================
module dot_lane_sum #(
   parameter int DATA_W = 32,
   parameter int MAX_N  = 16,
   parameter int LANES  = 2,
   parameter int ACC_W  = 68,
   parameter int IDX_W  = 5,
   parameter int NNZ_W  = 5
) (
   input  logic signed [DATA_W-1:0] a_i [MAX_N],
   input  logic signed [DATA_W-1:0] b_i [MAX_N],
   input  logic        [IDX_W-1:0]  idx_i,
   input  logic        [NNZ_W-1:0]  n_i,
   output logic signed [ACC_W-1:0]  sum_o
);

   logic signed [DATA_W-1:0]   lane_a;
   logic signed [DATA_W-1:0]   lane_b;
   logic signed [2*DATA_W-1:0] prod;
   logic signed [ACC_W-1:0]    sum;

   // Select each lane's operands by index match, multiply, and reduce
   always_comb begin
      sum    = '0;
      lane_a = '0;
      lane_b = '0;
      prod   = '0;
      for (int k = 0; k < LANES; k++) begin
         lane_a = '0;
         lane_b = '0;
         for (int m = 0; m < MAX_N; m++) begin
            if ((m == int'(idx_i) + k) && (m < int'(n_i))) begin
               lane_a = a_i[m];
               lane_b = b_i[m];
            end
         end
         prod = (2*DATA_W)'(lane_a) * (2*DATA_W)'(lane_b);
         sum  = sum + ACC_W'(prod);
      end
   end

   assign sum_o = sum;

endmodule
`default_nettype wire

// File: rtl/sparse_dot_engine.sv
`default_nettype none
// ============================================================================
//  Module   : sparse_dot_engine
//  Purpose  : Multi-lane sparse dot-product engine with bias, optional ReLU,
//             saturating narrowing, overflow flag and valid/ready result.
//  Revision : 1.0 - initial release
// ============================================================================
module sparse_dot_engine
   import sparse_dot_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int MAX_N  = 16,
   parameter int LANES  = 2,
   // Default is the narrowest width that cannot overflow for the other defaults
   parameter int ACC_W  = 2*DATA_W + $clog2(MAX_N),
   parameter int OUT_W  = 32
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          start_i,
   input  logic [$clog2(MAX_N+1)-1:0]    nnz_i,
   input  logic [MAX_N*DATA_W-1:0]       a_i,
   input  logic [MAX_N*DATA_W-1:0]       b_i,
   input  logic [DATA_W-1:0]             c_i,
   input  logic                          relu_i,
   input  logic                          sat_i,
   input  logic                          result_ready_i,
   output logic [OUT_W-1:0]              result_o,
   output logic                          result_valid_o,
   output logic                          busy_o,
   output logic                          overflow_o,
   output logic [CNT_W-1:0]              cycle_count_o
);

   localparam int NNZ_W = $clog2(MAX_N+1);
   localparam int IDX_W = idx_width(MAX_N, LANES);

   // Elaboration-time parameter legality
   if (ACC_W < 2*DATA_W + $clog2(MAX_N)) begin : g_chk_acc_w
      $error("ACC_W too narrow for DATA_W/MAX_N");
   end
   if (LANES < 1 || LANES > MAX_N) begin : g_chk_lanes
      $error("LANES must lie in 1..MAX_N");
   end
   if (OUT_W > ACC_W) begin : g_chk_out_w
      $error("OUT_W must not exceed ACC_W");
   end
   if (ACC_W > SAT_MAX_W) begin : g_chk_sat_w
      $error("ACC_W exceeds narrowing function width");
   end

   state_t                   state_q;
   logic                     start_prev_q;
   logic signed [DATA_W-1:0] a_q [MAX_N];
   logic signed [DATA_W-1:0] b_q [MAX_N];
   logic signed [DATA_W-1:0] c_q;
   logic                     relu_q;
   logic                     sat_q;
   logic [NNZ_W-1:0]         n_q;
   logic [IDX_W-1:0]         idx_q;
   logic signed [ACC_W-1:0]  acc_q;
   logic [CNT_W-1:0]         cnt_q;
   logic [OUT_W-1:0]         result_q;
   logic                     valid_q;
   logic                     busy_q;
   logic                     ovf_q;
   logic [CNT_W-1:0]         cc_q;

   logic                     start_edge;
   logic [NNZ_W-1:0]         n_d;
   logic [IDX_W-1:0]         idx_d;
   logic                     last_step;
   logic signed [ACC_W-1:0]  lane_sum;
   logic signed [ACC_W-1:0]  acc_d;
   logic signed [ACC_W-1:0]  biased;
   logic signed [ACC_W-1:0]  post_relu;
   sat_res_t                 narrowed;
   logic [OUT_W-1:0]         result_d;
   logic [SAT_MAX_W-OUT_W:0] sat_unused;

   assign start_edge = start_i & ~start_prev_q;
   assign n_d        = (nnz_i > NNZ_W'(MAX_N)) ? NNZ_W'(MAX_N) : nnz_i;
   assign idx_d      = idx_q + IDX_W'(LANES);
   assign last_step  = (idx_d >= IDX_W'(n_q));
   assign acc_d      = acc_q + lane_sum;

   dot_lane_sum #(
      .DATA_W (DATA_W),
      .MAX_N  (MAX_N),
      .LANES  (LANES),
      .ACC_W  (ACC_W),
      .IDX_W  (IDX_W),
      .NNZ_W  (NNZ_W)
   ) u_lane_sum (
      .a_i   (a_q),
      .b_i   (b_q),
      .idx_i (idx_q),
      .n_i   (n_q),
      .sum_o (lane_sum)
   );

   // Post-processing of the final accumulator: bias, ReLU, narrowing
   assign biased     = acc_q + ACC_W'(c_q);
   assign post_relu  = (relu_q && biased[ACC_W-1]) ? '0 : biased;
   assign narrowed   = sat_narrow(SAT_MAX_W'(post_relu), OUT_W, sat_q);
   assign result_d   = narrowed.value[OUT_W-1:0];
   assign sat_unused = {narrowed.value[SAT_MAX_W-1:OUT_W], 1'b0};

   // Engine sequencer: capture, multi-lane accumulate, finish, handshake
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         start_prev_q <= 1'b0;
         for (int m = 0; m < MAX_N; m++) begin
            a_q[m] <= '0;
            b_q[m] <= '0;
         end
         c_q      <= '0;
         relu_q   <= 1'b0;
         sat_q    <= 1'b0;
         n_q      <= '0;
         idx_q    <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         ovf_q    <= 1'b0;
         cc_q     <= '0;
      end else begin
         start_prev_q <= start_i;
         case (state_q)
            ST_IDLE: begin
               if (start_edge) begin
                  for (int m = 0; m < MAX_N; m++) begin
                     a_q[m] <= a_i[m*DATA_W +: DATA_W];
                     b_q[m] <= b_i[m*DATA_W +: DATA_W];
                  end
                  c_q     <= c_i;
                  relu_q  <= relu_i;
                  sat_q   <= sat_i;
                  n_q     <= n_d;
                  idx_q   <= '0;
                  acc_q   <= '0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= (n_d == '0) ? ST_FINISH : ST_COMPUTE;
               end
            end
            ST_COMPUTE: begin
               acc_q <= acc_d;
               idx_q <= idx_d;
               cnt_q <= cnt_q + CNT_W'(1);
               if (last_step) begin
                  state_q <= ST_FINISH;
               end
            end
            ST_FINISH: begin
               result_q <= result_d;
               ovf_q    <= narrowed.clipped;
               cc_q     <= cnt_q;
               valid_q  <= 1'b1;
               busy_q   <= 1'b0;
               state_q  <= ST_DONE;
            end
            ST_DONE: begin
               if (result_ready_i) begin
                  valid_q <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign result_o       = result_q;
   assign result_valid_o = valid_q;
   assign busy_o         = busy_q;
   assign overflow_o     = ovf_q;
   assign cycle_count_o  = cc_q;

endmodule
`default_nettype wire

// File: tb/tb_sparse_dot_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sparse_dot_engine
//  Purpose  : Self-checking bench for sparse_dot_engine against a wide
//             arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sparse_dot_engine;

   localparam int DATA_W = 32;
   localparam int MAX_N  = 16;
   localparam int LANES  = 2;
   localparam int ACC_W  = 68;
   localparam int OUT_W  = 32;
   localparam int NNZ_W  = $clog2(MAX_N+1);

   localparam logic signed [127:0] I32_MAX = 128'sd2147483647;
   localparam logic signed [127:0] I32_MIN = -128'sd2147483648;

   logic                     clk_i = 1'b0;
   logic                     rst_i;
   logic                     start_i;
   logic [NNZ_W-1:0]         nnz_i;
   logic [MAX_N*DATA_W-1:0]  a_i;
   logic [MAX_N*DATA_W-1:0]  b_i;
   logic [DATA_W-1:0]        c_i;
   logic                     relu_i;
   logic                     sat_i;
   logic                     result_ready_i;
   logic [OUT_W-1:0]         result_o;
   logic                     result_valid_o;
   logic                     busy_o;
   logic                     overflow_o;
   logic [31:0]              cycle_count_o;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] ta [MAX_N];
   logic [31:0] tb [MAX_N];

   sparse_dot_engine #(
      .DATA_W (DATA_W),
      .MAX_N  (MAX_N),
      .LANES  (LANES),
      .ACC_W  (ACC_W),
      .OUT_W  (OUT_W)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .start_i        (start_i),
      .nnz_i          (nnz_i),
      .a_i            (a_i),
      .b_i            (b_i),
      .c_i            (c_i),
      .relu_i         (relu_i),
      .sat_i          (sat_i),
      .result_ready_i (result_ready_i),
      .result_o       (result_o),
      .result_valid_o (result_valid_o),
      .busy_o         (busy_o),
      .overflow_o     (overflow_o),
      .cycle_count_o  (cycle_count_o)
   );

   always #5 clk_i = ~clk_i;

   // Global time limit
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: exact wide sum, wrap to ACC_W, bias, ReLU, narrow
   task automatic model(input int nnz, input logic [31:0] c, input logic relu, input logic sat,
                        output logic [31:0] res, output logic ovf, output int cycles);
      int                  n;
      logic signed [127:0] acc;
      logic signed [127:0] pa;
      logic signed [127:0] pb;
      logic signed [127:0] s;
      n   = (nnz > MAX_N) ? MAX_N : nnz;
      acc = '0;
      for (int i = 0; i < n; i++) begin
         pa  = {{96{ta[i][31]}}, ta[i]};
         pb  = {{96{tb[i][31]}}, tb[i]};
         acc = acc + pa * pb;
      end
      s = acc + {{96{c[31]}}, c};
      s = (s <<< (128 - ACC_W)) >>> (128 - ACC_W);
      if (relu && s < 0) s = '0;
      ovf = 1'b0;
      if (sat) begin
         if (s > I32_MAX) begin
            s   = I32_MAX;
            ovf = 1'b1;
         end else if (s < I32_MIN) begin
            s   = I32_MIN;
            ovf = 1'b1;
         end
      end
      res    = s[31:0];
      cycles = (n + LANES - 1) / LANES;
   endtask

   task automatic drive_ops();
      for (int i = 0; i < MAX_N; i++) begin
         a_i[i*DATA_W +: DATA_W] = ta[i];
         b_i[i*DATA_W +: DATA_W] = tb[i];
      end
   endtask

   task automatic scramble_inputs();
      a_i    = {MAX_N{$urandom}};
      b_i    = {MAX_N{$urandom}};
      c_i    = $urandom;
      nnz_i  = NNZ_W'($urandom);
      relu_i = 1'($urandom);
      sat_i  = 1'($urandom);
   endtask

   // One full operation: start, scramble inputs mid-flight, wait, check, handshake
   task automatic run_op(input int nnz, input logic [31:0] c, input logic relu, input logic sat,
                         input int hold, input bit pulse_start, input bit start_with_ready);
      logic [31:0] e_res;
      logic        e_ovf;
      int          e_cyc;
      int          edges;
      model(nnz, c, relu, sat, e_res, e_ovf, e_cyc);
      @(negedge clk_i);
      drive_ops();
      c_i     = c;
      nnz_i   = NNZ_W'(nnz);
      relu_i  = relu;
      sat_i   = sat;
      start_i = 1'b1;
      @(posedge clk_i);
      #1;
      check_eq("busy_after_start", 64'(busy_o), 64'd1);
      @(negedge clk_i);
      start_i = 1'b0;
      scramble_inputs();
      edges = 0;
      while (!result_valid_o && edges < 200) begin
         @(posedge clk_i);
         #1;
         edges++;
      end
      check_eq("latency", 64'(edges), 64'(e_cyc + 1));
      check_eq("busy_at_valid", 64'(busy_o), 64'd0);
      check_eq("result", 64'(result_o), 64'(e_res));
      check_eq("overflow", 64'(overflow_o), 64'(e_ovf));
      check_eq("cycle_count", 64'(cycle_count_o), 64'(e_cyc));
      for (int h = 0; h < hold; h++) begin
         @(negedge clk_i);
         if (pulse_start && h == 3) start_i = 1'b1;
         if (pulse_start && h == 4) start_i = 1'b0;
         check_eq("hold_valid", 64'(result_valid_o), 64'd1);
         check_eq("hold_busy", 64'(busy_o), 64'd0);
         check_eq("hold_result", 64'(result_o), 64'(e_res));
      end
      @(negedge clk_i);
      start_i        = 1'b0;
      result_ready_i = 1'b1;
      if (start_with_ready) start_i = 1'b1;
      @(posedge clk_i);
      #1;
      check_eq("valid_after_ready", 64'(result_valid_o), 64'd0);
      if (start_with_ready) begin
         @(posedge clk_i);
         #1;
         check_eq("no_restart", 64'(busy_o), 64'd0);
      end
      @(negedge clk_i);
      start_i        = 1'b0;
      result_ready_i = 1'b0;
   endtask

   task automatic rand_ops(input bit big);
      for (int i = 0; i < MAX_N; i++) begin
         if (big) begin
            ta[i] = $urandom;
            tb[i] = $urandom;
         end else begin
            ta[i] = $urandom_range(2000, 0) - 1000;
            tb[i] = $urandom_range(2000, 0) - 1000;
         end
      end
   endtask

   initial begin
      logic [31:0] rc;
      rst_i          = 1'b1;
      start_i        = 1'b0;
      nnz_i          = '0;
      a_i            = '0;
      b_i            = '0;
      c_i            = '0;
      relu_i         = 1'b0;
      sat_i          = 1'b0;
      result_ready_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      check_eq("rst_result", 64'(result_o), 64'd0);
      check_eq("rst_valid", 64'(result_valid_o), 64'd0);
      check_eq("rst_busy", 64'(busy_o), 64'd0);
      check_eq("rst_overflow", 64'(overflow_o), 64'd0);
      check_eq("rst_cycle_count", 64'(cycle_count_o), 64'd0);
      @(negedge clk_i);
      rst_i = 1'b0;

      // Basic sum with non-zero junk beyond nnz
      rand_ops(1'b1);
      for (int i = 0; i < 5; i++) begin
         ta[i] = 32'(i + 1);
         tb[i] = 32'd1;
      end
      run_op(5, 32'd10, 1'b0, 1'b0, 0, 1'b0, 1'b0);

      // Empty operand list, negative bias clamped by ReLU
      run_op(0, -32'sd7, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      // Empty operand list, negative bias passed through
      run_op(0, -32'sd7, 1'b0, 1'b1, 0, 1'b0, 1'b0);

      // Positive overflow: saturate vs truncate
      ta[0] = 32'h7FFF_FFFF;
      tb[0] = 32'h7FFF_FFFF;
      run_op(1, 32'd0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
      run_op(1, 32'd0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      // Negative overflow saturates to the minimum
      ta[0] = 32'h8000_0000;
      tb[0] = 32'h7FFF_FFFF;
      run_op(1, 32'd0, 1'b0, 1'b1, 0, 1'b0, 1'b0);

      // Result held under back-pressure; starts in DONE ignored
      rand_ops(1'b0);
      run_op(7, 32'd3, 1'b0, 1'b1, 10, 1'b1, 1'b1);

      // nnz above MAX_N clamps to MAX_N
      rand_ops(1'b0);
      run_op(31, $urandom, 1'b0, 1'b0, 0, 1'b0, 1'b0);

      // Reset during COMPUTE clears outputs at once
      rand_ops(1'b1);
      @(negedge clk_i);
      drive_ops();
      nnz_i   = NNZ_W'(16);
      c_i     = 32'd5;
      start_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      start_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #2;
      rst_i = 1'b1;
      #1;
      check_eq("midrst_result", 64'(result_o), 64'd0);
      check_eq("midrst_valid", 64'(result_valid_o), 64'd0);
      check_eq("midrst_busy", 64'(busy_o), 64'd0);
      check_eq("midrst_overflow", 64'(overflow_o), 64'd0);
      check_eq("midrst_cycle_count", 64'(cycle_count_o), 64'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      run_op(16, 32'd5, 1'b0, 1'b0, 0, 1'b0, 1'b0);

      // Randomized operations
      for (int t = 0; t < 40; t++) begin
         rand_ops(1'($urandom));
         rc = ($urandom_range(1, 0) == 1) ? $urandom : ($urandom_range(200, 0) - 100);
         run_op(int'($urandom_range(20, 0)), rc, 1'($urandom), 1'($urandom),
                int'($urandom_range(3, 0)), 1'b0, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
